// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 mux among 8 requesters.
// Holds each grant for a bounded time and captures the mux output as a tagged sample.
module mux8_rr_scheduler #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       mux_y,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       mux_en_n,
  output logic       busy,
  output logic       sample_valid,
  output logic       sample_data,
  output logic [2:0] sample_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [7:0] grant_nxt;
  logic [2:0] sel_nxt;
  logic       mux_en_n_nxt;
  logic       busy_nxt;
  logic       sample_valid_nxt;
  logic       sample_data_nxt;
  logic [2:0] sample_idx_nxt;

  logic       found_c;
  logic [2:0] win_c;
  logic [2:0] arb_idx_c;
  logic       exit_c;

  // Rotating priority search starting at ptr; sel always holds the current grantee
  always_comb begin
    found_c   = 1'b0;
    win_c     = ptr;
    arb_idx_c = ptr;
    for (int unsigned d = 0; d < 8; d++) begin
      arb_idx_c = ptr + 3'(d);
      if (!found_c && req[arb_idx_c]) begin
        found_c = 1'b1;
        win_c   = arb_idx_c;
      end
    end
  end

  assign exit_c = done || !req[sel] || (cnt == CNT_W'(HOLD_CYCLES - 1));

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= 3'd0;
      cnt          <= '0;
      grant        <= 8'd0;
      sel          <= 3'd0;
      mux_en_n     <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= 1'b0;
      sample_idx   <= 3'd0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      cnt          <= cnt_nxt;
      grant        <= grant_nxt;
      sel          <= sel_nxt;
      mux_en_n     <= mux_en_n_nxt;
      busy         <= busy_nxt;
      sample_valid <= sample_valid_nxt;
      sample_data  <= sample_data_nxt;
      sample_idx   <= sample_idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found_c) state_nxt = S_GRANT;
      S_GRANT: if (exit_c) state_nxt = S_GAP;
      S_GAP:   state_nxt = found_c ? S_GRANT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    ptr_nxt          = ptr;
    cnt_nxt          = cnt;
    grant_nxt        = grant;
    sel_nxt          = sel;
    mux_en_n_nxt     = mux_en_n;
    busy_nxt         = busy;
    sample_valid_nxt = 1'b0;
    sample_data_nxt  = sample_data;
    sample_idx_nxt   = sample_idx;
    case (state)
      S_GRANT: begin
        if (exit_c) begin
          sample_valid_nxt = 1'b1;
          sample_data_nxt  = mux_y;
          sample_idx_nxt   = sel;
          grant_nxt        = 8'd0;
          mux_en_n_nxt     = 1'b1;
          busy_nxt         = 1'b0;
          ptr_nxt          = sel + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (found_c) begin
          grant_nxt    = 8'd1 << win_c;
          sel_nxt      = win_c;
          mux_en_n_nxt = 1'b0;
          busy_nxt     = 1'b1;
          cnt_nxt      = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: two instances (hold 4 and hold 1) driven by shared
// directed and random stimulus, compared every cycle against a cycle-count model.
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       mux_y;

  logic [7:0] grant0, grant1;
  logic [2:0] sel0, sel1, sidx0, sidx1;
  logic       en_n0, en_n1, busy0, busy1, sv0, sv1, sd0, sd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.HOLD_CYCLES(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .done(done), .mux_y(mux_y),
    .grant(grant0), .sel(sel0), .mux_en_n(en_n0), .busy(busy0),
    .sample_valid(sv0), .sample_data(sd0), .sample_idx(sidx0)
  );

  mux8_rr_scheduler #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done), .mux_y(mux_y),
    .grant(grant1), .sel(sel1), .mux_en_n(en_n1), .busy(busy1),
    .sample_valid(sv1), .sample_data(sd1), .sample_idx(sidx1)
  );

  // Model state per instance: whether a grantee holds the mux and for how many cycles
  int         hold_of  [2] = '{4, 1};
  int         m_active [2];
  int         m_w      [2];
  int         m_age    [2];
  int         m_ptr    [2];
  logic [7:0] e_grant  [2];
  logic [2:0] e_sel    [2];
  logic       e_en_n   [2];
  logic       e_busy   [2];
  logic       e_sv     [2];
  logic       e_sd     [2];
  logic [2:0] e_si     [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int u);
    if (rst) begin
      m_active[u] = 0; m_w[u] = 0; m_age[u] = 0; m_ptr[u] = 0;
      e_sel[u] = 3'd0; e_sv[u] = 1'b0; e_sd[u] = 1'b0; e_si[u] = 3'd0;
    end else begin
      e_sv[u] = 1'b0;
      if (m_active[u] != 0) begin
        m_age[u]++;
        if (m_age[u] == hold_of[u] || done || !req[m_w[u]]) begin
          e_sd[u]     = mux_y;
          e_si[u]     = 3'(m_w[u]);
          e_sv[u]     = 1'b1;
          m_active[u] = 0;
          m_ptr[u]    = (m_w[u] + 1) % 8;
        end
      end else begin
        for (int d = 0; d < 8; d++) begin
          int k;
          k = (m_ptr[u] + d) % 8;
          if (req[k]) begin
            m_active[u] = 1;
            m_w[u]      = k;
            m_age[u]    = 0;
            e_sel[u]    = 3'(k);
            break;
          end
        end
      end
    end
    e_grant[u] = (m_active[u] != 0) ? (8'd1 << m_w[u]) : 8'd0;
    e_en_n[u]  = (m_active[u] == 0);
    e_busy[u]  = (m_active[u] != 0);
  endtask

  task automatic compare_unit(input int u, input logic [7:0] g, input logic [2:0] s,
                              input logic en, input logic b, input logic v,
                              input logic d, input logic [2:0] si);
    string p;
    p = (u == 0) ? "h4" : "h1";
    chk({p, ".grant"}, g, e_grant[u]);
    chk({p, ".sel"}, 8'(s), 8'(e_sel[u]));
    chk({p, ".mux_en_n"}, 8'(en), 8'(e_en_n[u]));
    chk({p, ".busy"}, 8'(b), 8'(e_busy[u]));
    chk({p, ".sample_valid"}, 8'(v), 8'(e_sv[u]));
    if (e_sv[u]) begin
      chk({p, ".sample_data"}, 8'(d), 8'(e_sd[u]));
      chk({p, ".sample_idx"}, 8'(si), 8'(e_si[u]));
    end
  endtask

  // One clock: advance the model on the same edge, then compare shortly after it
  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    compare_unit(0, grant0, sel0, en_n0, busy0, sv0, sd0, sidx0);
    compare_unit(1, grant1, sel1, en_n1, busy1, sv1, sd1, sidx1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'd0; done = 1'b0; mux_y = 1'b0;
    #2;

    // Reset values
    do_reset();
    chk("reset.grant", grant0, 8'h00);
    chk("reset.mux_en_n", 8'(en_n0), 8'h01);
    chk("reset.sample_idx", 8'(sidx0), 8'h00);

    // Single requester held: 4-cycle grants, sample, re-grant
    req = 8'h04; mux_y = 1'b1;
    step();
    chk("single.grant", grant0, 8'h04);
    chk("single.sel", 8'(sel0), 8'h02);
    run(4);
    chk("single.gap_valid", 8'(sv0), 8'h01);
    chk("single.gap_idx", 8'(sidx0), 8'h02);
    chk("single.gap_data", 8'(sd0), 8'h01);
    step();
    chk("single.regrant", grant0, 8'h04);
    run(6);

    // All requesting: rotation 0..7 and wrap
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 42; i++) begin
      mux_y = 1'(i % 3);
      step();
    end

    // Early done on the second cycle of grant 5
    do_reset();
    req = 8'h20;
    run(2);
    done = 1'b1;
    req = 8'h61;
    step();
    done = 1'b0;
    chk("done.idx", 8'(sidx0), 8'h05);
    step();
    chk("done.next", grant0, 8'h40);
    run(6);

    // req[3] dropped mid-grant with req[6] pending
    do_reset();
    req = 8'h48;
    run(2);
    req = 8'h40;
    step();
    chk("drop.gap", grant0, 8'h00);
    step();
    chk("drop.next", grant0, 8'h40);
    run(4);

    // Reset during grant 7, then restart with ptr back at 0
    do_reset();
    req = 8'h80;
    run(2);
    chk("rstmid.grant", grant0, 8'h80);
    rst = 1'b1;
    step();
    chk("rstmid.valid", 8'(sv0), 8'h00);
    rst = 1'b0;
    req = 8'h81;
    step();
    chk("rstmid.restart", grant0, 8'h01);
    run(3);

    // Two requesters: the hold-1 instance alternates GRANT/GAP
    do_reset();
    req = 8'h03;
    for (int i = 0; i < 12; i++) begin
      mux_y = 1'($urandom_range(0, 1));
      step();
    end

    // Randomized traffic with occasional done pulses and resets
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      done  = ($urandom_range(0, 5) == 0);
      mux_y = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares the single-bit output of the 8:1 multiplexer (multiplexer8_1) among 8 requesters.
- Drives the mux select lines ({a,b,c}) and the active-low enable (e).
- Holds each grant for a bounded number of cycles, then captures the mux output y as a tagged sample.
- Sits between the requesting logic and the mux instance; the mux itself stays purely combinational.

Parameters:
- HOLD_CYCLES, 4, maximum cycles a grant lasts; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  request lines; req[k] asks for mux input i[k].
- done  input  1  current grantee finished; ends the grant early.
- mux_y  input  1  y output of the 8:1 mux.
- grant  output  8  one-hot grant, registered; all zero when idle.
- sel  output  3  mux select; sel[2]=a, sel[1]=b, sel[0]=c; registered.
- mux_en_n  output  1  mux enable e, active-low; 0 only while a grant is active.
- busy  output  1  1 in GRANT state.
- sample_valid  output  1  one-cycle pulse, sample_data/sample_idx valid.
- sample_data  output  1  mux_y captured on last GRANT cycle.
- sample_idx  output  3  index of the requester the sample belongs to.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, grant=0, sel=0, mux_en_n=1, busy=0, sample_valid=0, sample_data=0, sample_idx=0, rr pointer=0, hold counter=0.
- Reset wins over every other event, including mid-grant: no sample is produced for the aborted grant.
- States: IDLE, GRANT, GAP.
- Arbitration (combinational, evaluated in IDLE and GAP):
  - Winner is the first k with req[k]=1, searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - No winner: stay in IDLE, or go from GAP to IDLE.
- Grant entry (arbitration at edge t finds winner w):
  - From edge t: state=GRANT, grant=1<<w, sel=w, mux_en_n=0, busy=1, counter=0.
  - Latency from req assertion seen in IDLE to grant: 1 cycle.
- In GRANT:
  - Counter increments each cycle.
  - Exit condition at an edge: counter==HOLD_CYCLES-1, OR done=1, OR req[w]=0. Any combination exits once.
  - On exit edge:
    - sample_data<=mux_y (value present during the final GRANT cycle) and sample_idx<=w.
    - sample_valid<=1; state=GAP.
    - grant=0, mux_en_n=1, busy=0; sel holds w.
    - ptr<=(w+1) mod 8; wraps 7->0.
- GAP:
  - Exactly 1 cycle; sample_valid=1 only here.
  - Mux disabled for one cycle between grants (break-before-make).
  - Arbitrates with the updated ptr, then goes to GRANT or IDLE.
- With HOLD_CYCLES=1: every grant lasts exactly 1 cycle.
- Continuous requests: period per grantee is HOLD_CYCLES+1 cycles.
- done or req changes outside GRANT are ignored except through arbitration.
- grant is always one-hot or zero. sel==index of grant bit whenever grant!=0.

Test Plan:
- Reset then req=8'b0000_0100 held, done=0, HOLD_CYCLES=4, mux_y=1:
  - 1 cycle later grant=0x04, sel=2, mux_en_n=0 for 4 cycles.
  - Then GAP with sample_valid=1, sample_data=1, sample_idx=2.
  - Re-grant to 2 after GAP.
- req=8'hFF constant:
  - Grants in order 0,1,...,7,0, each 4 cycles, separated by 1-cycle gaps with mux_en_n=1.
  - sample_idx sequence 0..7.
- Grant to 5 active, done=1 on 2nd grant cycle:
  - Grant ends after 2 cycles; sample_idx=5; next search starts at 6.
- Grant to 3, req[3] deasserted mid-grant while req[6]=1:
  - Grant ends at that edge; GAP; then grant=0x40, sel=6.
- rst=1 during GRANT (grant=0x80):
  - Next cycle all outputs at reset values; no sample_valid.
  - After release with req=0x81, first grant goes to 0 (ptr=0).
- HOLD_CYCLES=1, req=0x03:
  - Alternating grants 0,1,0,1 with pattern GRANT,GAP repeating.
  - sample_valid high on every GAP cycle.
